// File: rtl/stop_watch_lap_mem.sv
// ss.cc stopwatch with debounced start/lap/recall buttons and lap memory.
// A lap snapshot can be recalled to the 4-digit BCD display.
module stop_watch_lap_mem #(
   parameter  int CLK_FREQ_HZ = 100_000_000,
   parameter  int TICK_HZ     = 100,
   parameter  int LAP_DEPTH   = 8,
   parameter  int DEB_BITS    = 17,
   localparam int CNT_W       = $clog2(LAP_DEPTH + 1),
   localparam int IDX_W       = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_p,
   input  logic [2:0]       btn,
   output logic [15:0]      disp_bcd,
   output logic             running,
   output logic             view_mode,
   output logic [CNT_W-1:0] lap_cnt,
   output logic [IDX_W-1:0] view_idx,
   output logic             lap_full
);

   localparam int DIV  = CLK_FREQ_HZ / TICK_HZ;
   localparam int PS_W = $clog2(DIV);
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_VIEW  = 2'd3
   } state_t;

   // Advance {sec10, sec1, cs10, cs1} by one centisecond; 59.99 rolls to 00.00.
   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [15:0] n;
      n = t;
      if (t[3:0] != 4'd9) begin
         n[3:0] = t[3:0] + 4'd1;
      end else begin
         n[3:0] = 4'd0;
         if (t[7:4] != 4'd9) begin
            n[7:4] = t[7:4] + 4'd1;
         end else begin
            n[7:4] = 4'd0;
            if (t[11:8] != 4'd9) begin
               n[11:8] = t[11:8] + 4'd1;
            end else begin
               n[11:8]  = 4'd0;
               n[15:12] = (t[15:12] != 4'd5) ? t[15:12] + 4'd1 : 4'd0;
            end
         end
      end
      return n;
   endfunction

   logic [DEB_BITS-1:0] deb_div_r;
   logic [2:0]          btn_smp_r;
   logic [2:0]          btn_prev_r;
   logic [2:0]          pulse_s;
   logic                start_s, lap_s, rcl_s, tick_s;
   logic [PS_W-1:0]     ps_r;
   logic [15:0]         time_r;
   logic [15:0]         disp_r;
   logic [15:0]         mem_r [LAP_DEPTH];
   logic [CNT_W-1:0]    lap_cnt_r;
   logic [CNT_W-1:0]    last_idx_s;
   logic [IDX_W-1:0]    view_idx_r, idx_nx;
   logic                lap_full_r, running_r, view_mode_r;
   logic                lap_wr_s, lap_drop_s, clear_s, has_laps_s;
   state_t              state_r, state_nx, ret_r, ret_nx;

   // Slow sampling of the raw buttons plus rising-edge detection.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         deb_div_r  <= {DEB_BITS{1'b0}};
         btn_smp_r  <= 3'b000;
         btn_prev_r <= 3'b000;
      end else begin
         deb_div_r  <= deb_div_r + DEB_BITS'(1'b1);
         if (deb_div_r == {DEB_BITS{1'b1}}) begin
            btn_smp_r <= btn;
         end
         btn_prev_r <= btn_smp_r;
      end
   end

   assign pulse_s    = btn_smp_r & ~btn_prev_r;
   assign start_s    = pulse_s[0];
   assign lap_s      = pulse_s[1] & ~pulse_s[0];
   assign rcl_s      = pulse_s[2] & ~pulse_s[1] & ~pulse_s[0];
   assign tick_s     = (state_r == S_RUN) && (ps_r == PS_LAST);
   assign has_laps_s = (lap_cnt_r != {CNT_W{1'b0}});
   assign last_idx_s = lap_cnt_r - CNT_W'(1'b1);

   // Control state, return state and recall index registers.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         state_r    <= S_IDLE;
         ret_r      <= S_IDLE;
         view_idx_r <= {IDX_W{1'b0}};
      end else begin
         state_r    <= state_nx;
         ret_r      <= ret_nx;
         view_idx_r <= idx_nx;
      end
   end

   // Next-state decode; only the winning button pulse reaches this logic.
   always_comb begin
      state_nx   = state_r;
      ret_nx     = ret_r;
      idx_nx     = view_idx_r;
      lap_wr_s   = 1'b0;
      lap_drop_s = 1'b0;
      clear_s    = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start_s) begin
               state_nx = S_RUN;
            end else if (rcl_s && has_laps_s) begin
               state_nx = S_VIEW;
               ret_nx   = S_IDLE;
               idx_nx   = {IDX_W{1'b0}};
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_RUN: begin
            if (start_s) begin
               state_nx = S_PAUSE;
            end else if (lap_s) begin
               if (lap_cnt_r == CNT_W'(LAP_DEPTH)) begin
                  lap_drop_s = 1'b1;
               end else begin
                  lap_wr_s = 1'b1;
               end
            end else begin
               state_nx = S_RUN;
            end
         end
         S_PAUSE: begin
            if (start_s) begin
               state_nx = S_RUN;
            end else if (lap_s) begin
               clear_s  = 1'b1;
               state_nx = S_IDLE;
            end else if (rcl_s && has_laps_s) begin
               state_nx = S_VIEW;
               ret_nx   = S_PAUSE;
               idx_nx   = {IDX_W{1'b0}};
            end else begin
               state_nx = S_PAUSE;
            end
         end
         S_VIEW: begin
            if (start_s) begin
               state_nx = ret_r;
               idx_nx   = {IDX_W{1'b0}};
            end else if (rcl_s) begin
               if (CNT_W'(view_idx_r) == last_idx_s) begin
                  state_nx = ret_r;
                  idx_nx   = {IDX_W{1'b0}};
               end else begin
                  idx_nx = view_idx_r + IDX_W'(1'b1);
               end
            end else begin
               state_nx = S_VIEW;
            end
         end
         default: begin
            state_nx = S_IDLE;
            ret_nx   = S_IDLE;
            idx_nx   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Prescaler, BCD time, lap bookkeeping and registered display/status.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         ps_r        <= {PS_W{1'b0}};
         time_r      <= 16'h0000;
         lap_cnt_r   <= {CNT_W{1'b0}};
         lap_full_r  <= 1'b0;
         disp_r      <= 16'h0000;
         running_r   <= 1'b0;
         view_mode_r <= 1'b0;
      end else begin
         if (clear_s) begin
            ps_r       <= {PS_W{1'b0}};
            time_r     <= 16'h0000;
            lap_cnt_r  <= {CNT_W{1'b0}};
            lap_full_r <= 1'b0;
         end else begin
            if (state_r == S_RUN) begin
               ps_r <= tick_s ? {PS_W{1'b0}} : ps_r + PS_W'(1'b1);
            end
            if (tick_s) begin
               time_r <= bcd_inc(time_r);
            end
            if (lap_wr_s) begin
               lap_cnt_r <= lap_cnt_r + CNT_W'(1'b1);
            end
            if (lap_drop_s) begin
               lap_full_r <= 1'b1;
            end
         end
         disp_r      <= (state_r == S_VIEW) ? mem_r[view_idx_r] : time_r;
         running_r   <= (state_nx == S_RUN);
         view_mode_r <= (state_nx == S_VIEW);
      end
   end

   // Lap storage; the pre-tick time is captured even when a tick coincides.
   always_ff @(posedge clk or posedge rst_p) begin
      if (rst_p) begin
         for (int i = 0; i < LAP_DEPTH; i++) begin
            mem_r[i] <= 16'h0000;
         end
      end else if (lap_wr_s) begin
         mem_r[lap_cnt_r[IDX_W-1:0]] <= time_r;
      end
   end

   assign disp_bcd  = disp_r;
   assign running   = running_r;
   assign view_mode = view_mode_r;
   assign lap_cnt   = lap_cnt_r;
   assign view_idx  = view_idx_r;
   assign lap_full  = lap_full_r;

endmodule

// File: doc/stop_watch_lap_mem.md
Name: stop_watch_lap_mem

Overview:
Parametrised successor to the two-button ss.cc stopwatch.
- Debounces three buttons and generates its own centisecond tick from the system clock.
- Runs a BCD ss.cc time counter.
- Stores up to LAP_DEPTH lap snapshots in an internal memory and recalls them one by one.
- Outputs a 16-bit BCD value for the existing 4-digit FND controller, plus status flags for LEDs.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 100, time-base rate; one tick = one centisecond count. CLK_FREQ_HZ/TICK_HZ must be an integer ≥ 2.
- LAP_DEPTH, 8, number of lap entries stored (≥ 1).
- DEB_BITS, 17, debounce sample period is 2^DEB_BITS clocks.

Ports:
- clk  in  1  system clock
- rst_p  in  1  asynchronous, active-high reset
- btn  in  3  raw buttons: [0] start/stop, [1] lap/clear, [2] recall
- disp_bcd  out  16  {sec10, sec1, cs10, cs1} BCD to the FND controller
- running  out  1  high in RUN state
- view_mode  out  1  high in VIEW state
- lap_cnt  out  $clog2(LAP_DEPTH+1)  number of stored laps
- view_idx  out  $clog2(LAP_DEPTH) (min 1)  lap index being displayed
- lap_full  out  1  sticky: a lap was dropped because memory was full

Behaviour:
- Reset (async, rst_p=1): all registers, outputs, time, lap memory valid count and state return to 0/IDLE. disp_bcd=16'h0000.
- Debounce: a free-running DEB_BITS-bit divider. Each btn bit is sampled into a register when the divider wraps. A rising edge of the sampled bit gives a 1-clk pulse (start_p, lap_p, rcl_p) in the clk domain.
- Same-cycle pulses: priority start_p > lap_p > rcl_p; only the highest-priority pulse acts, the others are discarded.
- Prescaler: counts 0..CLK_FREQ_HZ/TICK_HZ-1 and advances only in RUN. It is frozen, not cleared, in PAUSE/VIEW. It is cleared on clear and on reset. The terminal count gives a 1-clk tick.
- Time counter (BCD) on tick:
  - cs1 wraps 9→0 and carries to cs10.
  - cs10 wraps 9→0 and carries to sec1.
  - sec1 wraps 9→0 and carries to sec10.
  - sec10 wraps 5→0.
  - 59.99 → 00.00; no flag, counting continues.
- States:
  - IDLE: time 00.00.
    - start_p → RUN.
    - rcl_p with lap_cnt>0 → VIEW (ret=IDLE, view_idx=0).
    - lap_p ignored.
  - RUN:
    - start_p → PAUSE.
    - lap_p stores the live time in mem[lap_cnt] and increments lap_cnt. If lap_cnt==LAP_DEPTH, it stores nothing and sets lap_full.
    - rcl_p ignored.
  - PAUSE:
    - start_p → RUN.
    - lap_p = clear: time, prescaler, lap_cnt and lap_full go to 0 → IDLE.
    - rcl_p with lap_cnt>0 → VIEW (ret=PAUSE, view_idx=0).
  - VIEW:
    - rcl_p: view_idx+1. If view_idx==lap_cnt-1, return to ret and view_idx goes to 0.
    - start_p: return to ret immediately; no run toggle.
    - lap_p ignored.
- Lap capture with a coincident tick: the stored value is the pre-increment time. The live counter still increments that cycle.
- disp_bcd is registered, 1 clk after the source changes:
  - VIEW: mem[view_idx].
  - Otherwise: live time.
- Memory: LAP_DEPTH × 16 registers. Contents are not cleared on clear; lap_cnt gates validity.
- lap_full stays set until clear or reset.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=1000, TICK_HZ=100 (10 clk/tick), DEB_BITS=2, LAP_DEPTH=4.
- Reset mid-RUN at time 12.34 → all outputs 0 on the same edge as rst_p; state IDLE after release; disp_bcd=0000.
- Press start, run 1000 ticks → disp_bcd=16'h1000 (10.00), running=1. Press start again → running=0, and disp_bcd is unchanged over a further 500 clks.
- Run from 59.95 for 6 ticks → 59.99 followed by 00.00, then 00.01.
- In RUN, press lap at 00.50 and 01.25 → lap_cnt=2. Pause, press recall → view_mode=1 and disp 0050. Recall → 0125. Recall → view_mode=0, disp shows the paused time.
- Press lap 5 times in RUN → lap_cnt=4, lap_full=1. Pause, press lap → IDLE, lap_cnt=0, lap_full=0, disp 0000. Recall then ignored.
- Assert start and lap raw in the same sample in IDLE → only RUN is entered, lap_cnt=0. Lap pulse coincident with tick at 00.09→00.10 → stored 0009.
